sting_axi_regs: RTL and testbench

AXI4-Lite slave register file for the sting CNN accelerator; it sits between the AXI interconnect and the sting core datapath. It holds the layer configuration registers: input/output geometry, DMA start addresses, weight addresses, filter/neuron counts and the leaky-ReLU coefficient. It generates soft-reset/run pulses and a level interrupt on core completion.

---
 rtl/sting_reg_pkg.sv | 48 ++++
 rtl/sting_axil_slave.sv | 90 +++++++++
 rtl/sting_axi_regs.sv | 158 +++++++++++++++
 tb/tb_sting_axi_regs.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sting_reg_pkg.sv
// sting register map: word indices, bit positions and byte-merge helper.
// Shared by the AXI4-Lite slave and the register file.
package sting_reg_pkg;

  localparam int IDX_W = 6;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_CTRL   = 6'h00;
  localparam idx_t IDX_MODE   = 6'h01;
  localparam idx_t IDX_IXSIZE = 6'h02;
  localparam idx_t IDX_IYSIZE = 6'h03;
  localparam idx_t IDX_ISADR  = 6'h04;
  localparam idx_t IDX_IFSIZE = 6'h05;
  localparam idx_t IDX_WSADR1 = 6'h06;
  localparam idx_t IDX_WSADR2 = 6'h07;
  localparam idx_t IDX_OSADR  = 6'h08;
  localparam idx_t IDX_OXSIZE = 6'h09;
  localparam idx_t IDX_OFSIZE = 6'h0A;
  localparam idx_t IDX_LRELU  = 6'h0B;
  localparam idx_t IDX_FNSIZE = 6'h0C;
  localparam idx_t IDX_STATUS = 6'h0D;

  localparam int CTRL_RESET = 0;
  localparam int CTRL_RUN   = 1;
  localparam int MODE_DIV   = 0;
  localparam int MODE_BN    = 1;
  localparam int MODE_LRELU = 2;
  localparam int ST_DONE    = 0;
  localparam int ST_IRQEN   = 1;

  localparam logic [31:0] RST_VAL = 32'h0;

  typedef enum logic [1:0] {
    RESP_OKAY = 2'b00
  } resp_e;

  function automatic logic [31:0] wmerge(
    input logic [31:0] cur,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = s[i] ? d[8*i +: 8] : cur[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sting_axil_slave.sv
// AXI4-Lite handshake front end: one write and one read in flight.
// Emits a single-cycle wr_en once both AW and W are captured.
module sting_axil_slave
  import sting_reg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                wr_en,
  output idx_t                wr_idx,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  output logic                rd_en,
  output idx_t                rd_idx,
  input  logic [DATA_W-1:0]   rd_data
);

  logic aw_full;
  logic w_full;
  logic unused_lsb;

  assign unused_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = !aw_full && !s_axi_bvalid;
  assign s_axi_wready  = !w_full && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rresp   = RESP_OKAY;

  assign wr_en  = aw_full && w_full;
  assign rd_en  = s_axi_arvalid && s_axi_arready;
  assign rd_idx = s_axi_araddr[IDX_W+1:2];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      wr_idx       <= '0;
      wr_data      <= '0;
      wr_strb      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        wr_idx  <= s_axi_awaddr[IDX_W+1:2];
      end else if (wr_en) begin
        aw_full <= 1'b0;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full  <= 1'b1;
        wr_data <= s_axi_wdata;
        wr_strb <= s_axi_wstrb;
      end else if (wr_en) begin
        w_full <= 1'b0;
      end
      if (wr_en)
        s_axi_bvalid <= 1'b1;
      else if (s_axi_bready)
        s_axi_bvalid <= 1'b0;
      if (rd_en) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sting_axi_regs.sv
// sting layer configuration register file behind an AXI4-Lite slave.
// Holds geometry/address config, run/reset pulses and the done interrupt.
module sting_axi_regs
  import sting_reg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic                core_done,
  output logic                soft_reset,
  output logic                run,
  output logic                mode_divmode,
  output logic                mode_bnen,
  output logic                mode_lreluen,
  output logic [15:0]         reg_axi_rd_input_xsize,
  output logic [15:0]         reg_axi_rd_input_ysize,
  output logic [31:0]         reg_axi_rd_input_start_adr,
  output logic [31:0]         reg_axi_rd_input_fsize,
  output logic [31:0]         reg_axi_rd_weight_start_adr1,
  output logic [31:0]         reg_axi_rd_weight_start_adr2,
  output logic [31:0]         reg_axi_rw_output_start_adr,
  output logic [15:0]         reg_axi_rw_output_xsize,
  output logic [15:0]         reg_axi_rw_output_fsize,
  output logic [15:0]         reg_fsize,
  output logic [15:0]         reg_nsize,
  output logic [31:0]         reg_leaky_relu,
  output logic                irq
);

  logic        wr_en;
  logic        rd_en;
  idx_t        wr_idx;
  idx_t        rd_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] rd_data;
  logic [31:0] wval;
  logic        done;
  logic        irqen;
  logic        done_clr;

  sting_axil_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slave (
    .aclk, .aresetn,
    .s_axi_awaddr, .s_axi_awvalid, .s_axi_awready,
    .s_axi_wdata, .s_axi_wstrb, .s_axi_wvalid, .s_axi_wready,
    .s_axi_bresp, .s_axi_bvalid, .s_axi_bready,
    .s_axi_araddr, .s_axi_arvalid, .s_axi_arready,
    .s_axi_rdata, .s_axi_rresp, .s_axi_rvalid, .s_axi_rready,
    .wr_en, .wr_idx, .wr_data, .wr_strb,
    .rd_en, .rd_idx, .rd_data
  );

  function automatic logic [31:0] rd_mux(input idx_t i);
    logic [31:0] r;
    r = '0;
    case (i)
      IDX_MODE:   r = {29'b0, mode_lreluen, mode_bnen, mode_divmode};
      IDX_IXSIZE: r = {16'b0, reg_axi_rd_input_xsize};
      IDX_IYSIZE: r = {16'b0, reg_axi_rd_input_ysize};
      IDX_ISADR:  r = reg_axi_rd_input_start_adr;
      IDX_IFSIZE: r = reg_axi_rd_input_fsize;
      IDX_WSADR1: r = reg_axi_rd_weight_start_adr1;
      IDX_WSADR2: r = reg_axi_rd_weight_start_adr2;
      IDX_OSADR:  r = reg_axi_rw_output_start_adr;
      IDX_OXSIZE: r = {16'b0, reg_axi_rw_output_xsize};
      IDX_OFSIZE: r = {16'b0, reg_axi_rw_output_fsize};
      IDX_LRELU:  r = reg_leaky_relu;
      IDX_FNSIZE: r = {reg_fsize, reg_nsize};
      IDX_STATUS: r = {30'b0, irqen, done};
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Byte strobes merge against the current value, so partial writes keep the rest.
  assign rd_data  = rd_mux(rd_idx);
  assign wval     = wmerge(rd_mux(wr_idx), wr_data, wr_strb);
  assign done_clr = wr_en && wr_idx == IDX_STATUS
                 && wr_strb[0] && wr_data[ST_DONE];
  assign irq      = done && irqen;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      soft_reset                   <= 1'b0;
      run                          <= 1'b0;
      mode_divmode                 <= 1'b0;
      mode_bnen                    <= 1'b0;
      mode_lreluen                 <= 1'b0;
      reg_axi_rd_input_xsize       <= RST_VAL[15:0];
      reg_axi_rd_input_ysize       <= RST_VAL[15:0];
      reg_axi_rd_input_start_adr   <= RST_VAL;
      reg_axi_rd_input_fsize       <= RST_VAL;
      reg_axi_rd_weight_start_adr1 <= RST_VAL;
      reg_axi_rd_weight_start_adr2 <= RST_VAL;
      reg_axi_rw_output_start_adr  <= RST_VAL;
      reg_axi_rw_output_xsize      <= RST_VAL[15:0];
      reg_axi_rw_output_fsize      <= RST_VAL[15:0];
      reg_leaky_relu               <= RST_VAL;
      reg_fsize                    <= RST_VAL[15:0];
      reg_nsize                    <= RST_VAL[15:0];
      irqen                        <= 1'b0;
      done                         <= 1'b0;
    end else begin
      soft_reset <= wr_en && wr_idx == IDX_CTRL && wval[CTRL_RESET];
      run        <= wr_en && wr_idx == IDX_CTRL && wval[CTRL_RUN];
      if (wr_en) begin
        case (wr_idx)
          IDX_MODE: begin
            mode_divmode <= wval[MODE_DIV];
            mode_bnen    <= wval[MODE_BN];
            mode_lreluen <= wval[MODE_LRELU];
          end
          IDX_IXSIZE: reg_axi_rd_input_xsize       <= wval[15:0];
          IDX_IYSIZE: reg_axi_rd_input_ysize       <= wval[15:0];
          IDX_ISADR:  reg_axi_rd_input_start_adr   <= wval;
          IDX_IFSIZE: reg_axi_rd_input_fsize       <= wval;
          IDX_WSADR1: reg_axi_rd_weight_start_adr1 <= wval;
          IDX_WSADR2: reg_axi_rd_weight_start_adr2 <= wval;
          IDX_OSADR:  reg_axi_rw_output_start_adr  <= wval;
          IDX_OXSIZE: reg_axi_rw_output_xsize      <= wval[15:0];
          IDX_OFSIZE: reg_axi_rw_output_fsize      <= wval[15:0];
          IDX_LRELU:  reg_leaky_relu               <= wval;
          IDX_FNSIZE: begin
            reg_fsize <= wval[31:16];
            reg_nsize <= wval[15:0];
          end
          IDX_STATUS: irqen <= wval[ST_IRQEN];
          default: ;
        endcase
      end
      // A completion in the same cycle as a clear must not be lost.
      if (core_done)
        done <= 1'b1;
      else if (done_clr)
        done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sting_axi_regs.sv
// Directed bench for sting_axi_regs: vector table plus handshake corners.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sting_axi_regs;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [7:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        core_done = 1'b0;
  logic        soft_reset, run;
  logic        mode_divmode, mode_bnen, mode_lreluen;
  logic [15:0] ixsize, iysize, oxsize, ofsize, fsize, nsize;
  logic [31:0] isadr, ifsize, wsadr1, wsadr2, osadr, lrelu;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int sr_cnt = 0;
  int run_cnt = 0;

  always #5 aclk = ~aclk;

  sting_axi_regs dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .core_done(core_done), .soft_reset(soft_reset), .run(run),
    .mode_divmode(mode_divmode), .mode_bnen(mode_bnen),
    .mode_lreluen(mode_lreluen),
    .reg_axi_rd_input_xsize(ixsize), .reg_axi_rd_input_ysize(iysize),
    .reg_axi_rd_input_start_adr(isadr), .reg_axi_rd_input_fsize(ifsize),
    .reg_axi_rd_weight_start_adr1(wsadr1),
    .reg_axi_rd_weight_start_adr2(wsadr2),
    .reg_axi_rw_output_start_adr(osadr),
    .reg_axi_rw_output_xsize(oxsize), .reg_axi_rw_output_fsize(ofsize),
    .reg_fsize(fsize), .reg_nsize(nsize),
    .reg_leaky_relu(lrelu), .irq(irq)
  );

  always @(negedge aclk) begin
    if (soft_reset) sr_cnt++;
    if (run) run_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int awd, input int wd);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs;
    int n = 0;
    s_axi_awaddr = a;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    while (!(aw_done && w_done) && n < 100) begin
      if (!aw_done && n >= awd) s_axi_awvalid = 1'b1;
      if (!w_done && n >= wd) s_axi_wvalid = 1'b1;
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(negedge aclk);
      if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin s_axi_wvalid = 1'b0; w_done = 1; end
      n++;
    end
    if (!(aw_done && w_done)) chk("aw_w_timeout", 32'(n), 32'd0);
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("bvalid", {31'b0, s_axi_bvalid}, 32'd1);
    @(negedge aclk);
    s_axi_bready = 1'b0;
    chk("bvalid_single", {31'b0, s_axi_bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
    int n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("rvalid", {31'b0, s_axi_rvalid}, 32'd1);
    d = s_axi_rdata;
    @(negedge aclk);
    s_axi_rready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd;
    int          wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] rd;

  initial begin
    vecs[0]  = '{8'h08, 32'd128,        4'hF, 0, 0, 32'd128};
    vecs[1]  = '{8'h0C, 32'd1024,       4'hF, 0, 0, 32'd1024};
    vecs[2]  = '{8'h10, 32'h8000_0000,  4'hF, 0, 0, 32'h8000_0000};
    vecs[3]  = '{8'h14, 32'h8001_0000,  4'hF, 0, 0, 32'h8001_0000};
    vecs[4]  = '{8'h18, 32'h8002_0000,  4'hF, 0, 0, 32'h8002_0000};
    vecs[5]  = '{8'h1C, 32'h8003_0000,  4'hF, 0, 0, 32'h8003_0000};
    vecs[6]  = '{8'h20, 32'h9000_0000,  4'hF, 0, 0, 32'h9000_0000};
    vecs[7]  = '{8'h24, 32'd64,         4'hF, 0, 0, 32'd64};
    vecs[8]  = '{8'h28, 32'd500,        4'hF, 0, 0, 32'd500};
    vecs[9]  = '{8'h2C, 32'h1234_5678,  4'hF, 0, 0, 32'h1234_5678};
    vecs[10] = '{8'h30, 32'h0200_0300,  4'hF, 0, 0, 32'h0200_0300};
    vecs[11] = '{8'h3C, 32'hFFFF_FFFF,  4'hF, 0, 0, 32'h0};
    vecs[12] = '{8'h2C, 32'hFFFF_FFFF,  4'h1, 0, 0, 32'h1234_56FF};
    vecs[13] = '{8'h24, 32'hFFFF_0040,  4'hF, 0, 3, 32'h0000_0040};
    vecs[14] = '{8'h28, 32'h0000_01F4,  4'hF, 3, 0, 32'h0000_01F4};

    #50;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    chk("rst_ixsize", {16'b0, ixsize}, 32'd0);
    chk("rst_lrelu", lrelu, 32'd0);
    chk("rst_mode", {29'b0, mode_lreluen, mode_bnen, mode_divmode}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
    for (int a = 8; a <= 8'h34; a += 4) begin
      axi_read(8'(a), rd);
      chk($sformatf("rst_rd_%02h", a), rd, 32'd0);
    end

    foreach (vecs[i]) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                vecs[i].awd, vecs[i].wd);
      axi_read(vecs[i].addr, rd);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end

    chk("out_ixsize", {16'b0, ixsize}, 32'd128);
    chk("out_iysize", {16'b0, iysize}, 32'd1024);
    chk("out_isadr", isadr, 32'h8000_0000);
    chk("out_ifsize", ifsize, 32'h8001_0000);
    chk("out_wsadr1", wsadr1, 32'h8002_0000);
    chk("out_wsadr2", wsadr2, 32'h8003_0000);
    chk("out_osadr", osadr, 32'h9000_0000);
    chk("out_oxsize", {16'b0, oxsize}, 32'd64);
    chk("out_ofsize", {16'b0, ofsize}, 32'd500);
    chk("out_lrelu", lrelu, 32'h1234_56FF);
    chk("out_fsize", {16'b0, fsize}, 32'h0200);
    chk("out_nsize", {16'b0, nsize}, 32'h0300);

    axi_write(8'h04, 32'h1, 4'hF, 0, 0);
    chk("mode1", {29'b0, mode_lreluen, mode_bnen, mode_divmode}, 32'h1);
    axi_write(8'h04, 32'h2, 4'hF, 0, 0);
    axi_write(8'h04, 32'h4, 4'hF, 0, 0);
    chk("mode_final", {29'b0, mode_lreluen, mode_bnen, mode_divmode}, 32'h4);
    axi_read(8'h04, rd);
    chk("mode_rd", rd, 32'h4);

    axi_write(8'h00, 32'h1, 4'hF, 0, 0);
    axi_write(8'h00, 32'h2, 4'hF, 0, 0);
    repeat (2) @(negedge aclk);
    chk("soft_reset_cnt", 32'(sr_cnt), 32'd1);
    chk("run_cnt", 32'(run_cnt), 32'd1);
    axi_read(8'h00, rd);
    chk("ctrl_rd", rd, 32'h0);

    axi_write(8'h34, 32'h2, 4'hF, 0, 0);
    chk("irq_en_only", {31'b0, irq}, 32'd0);
    core_done = 1'b1;
    @(negedge aclk);
    core_done = 1'b0;
    chk("irq_set", {31'b0, irq}, 32'd1);
    axi_read(8'h34, rd);
    chk("status_done", rd, 32'h3);
    axi_write(8'h34, 32'h3, 4'hF, 0, 0);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    axi_read(8'h34, rd);
    chk("status_clr", rd, 32'h2);

    // Clear write commits in the same cycle core_done fires.
    s_axi_awaddr  = 8'h34;
    s_axi_wdata   = 32'h3;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    core_done     = 1'b1;
    @(negedge aclk);
    core_done     = 1'b0;
    chk("race_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    chk("race_irq", {31'b0, irq}, 32'd1);
    axi_read(8'h34, rd);
    chk("race_status", rd, 32'h3);

    // Reset lands between handshake and commit: no response may follow.
    s_axi_awaddr  = 8'h2C;
    s_axi_wdata   = 32'hDEAD_BEEF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    aresetn       = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("abort_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
    chk("abort_lrelu", lrelu, 32'd0);
    chk("abort_irq", {31'b0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
